// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in clock ticks and flags loss of signal.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a filter_len-deep glitch filter on the input.
module pwm_capture #(
   parameter int clock_freq_hz   = 100_286_000,
   parameter int min_pwm_freq_hz = 50,
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   parameter int filter_len      = 4,
`endif
   parameter int counter_width   = $clog2(clock_freq_hz / min_pwm_freq_hz) + 1
) (
   input  logic                     pwm_clk,
   input  logic                     enable,
   input  logic                     pwm_in,
   output logic [counter_width-1:0] period_ticks,
   output logic [counter_width-1:0] high_ticks,
   output logic                     valid,
   output logic                     signal_lost,
   output logic                     level
);

   localparam int timeout_ticks = clock_freq_hz / min_pwm_freq_hz;
   localparam logic [counter_width-1:0] TIMEOUT_VAL = counter_width'(timeout_ticks);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   state_t                   r_state;
   logic                     r_sync1;
   logic                     r_sync2;
   logic                     r_lvlD;
   logic [counter_width-1:0] r_cnt;
   logic [counter_width-1:0] r_hiLat;
   logic [counter_width-1:0] r_periodTicks;
   logic [counter_width-1:0] r_highTicks;
   logic                     r_valid;
   logic                     r_signalLost;
   logic                     w_lvl;
   logic                     w_rise;
   logic                     w_fall;
   logic                     w_timeout;

   always_ff @(posedge pwm_clk or negedge enable) begin
      if (!enable) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FCNT_W = $clog2(filter_len) + 1;

   logic              r_lvl;
   logic [FCNT_W-1:0] r_fcnt;

   // The level flips only once the synchronized input has disagreed with it for filter_len cycles in a row.
   always_ff @(posedge pwm_clk or negedge enable) begin
      if (!enable) begin
         r_lvl  <= 1'b0;
         r_fcnt <= '0;
      end else if (r_sync2 == r_lvl) begin
         r_fcnt <= '0;
      end else if (r_fcnt == FCNT_W'(filter_len - 1)) begin
         r_lvl  <= r_sync2;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   assign w_lvl = r_lvl;
`else
   assign w_lvl = r_sync2;
`endif

   assign w_rise    = w_lvl & ~r_lvlD;
   assign w_fall    = ~w_lvl & r_lvlD;
   assign w_timeout = (r_cnt == TIMEOUT_VAL) && !w_rise;
   assign level     = w_lvl;

   always_ff @(posedge pwm_clk or negedge enable) begin
      if (!enable) begin
         r_lvlD <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_lvlD <= w_lvl;
         if (w_rise) begin
            r_cnt <= counter_width'(1);
         end else if (r_cnt != TIMEOUT_VAL) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // A rise arriving in the same cycle as the timeout is a valid period, so w_timeout already excludes it.
   always_ff @(posedge pwm_clk or negedge enable) begin
      if (!enable) begin
         r_state       <= S_IDLE;
         r_hiLat       <= '0;
         r_periodTicks <= '0;
         r_highTicks   <= '0;
         r_valid       <= 1'b0;
         r_signalLost  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (w_timeout) begin
                  r_signalLost  <= 1'b1;
                  r_periodTicks <= '0;
                  r_highTicks   <= '0;
                  r_state       <= S_IDLE;
               end else if (w_fall) begin
                  r_hiLat <= r_cnt;
                  r_state <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_rise) begin
                  r_periodTicks <= r_cnt;
                  r_highTicks   <= r_hiLat;
                  r_valid       <= 1'b1;
                  r_signalLost  <= 1'b0;
                  r_state       <= S_HIGH;
               end else if (w_timeout) begin
                  r_signalLost  <= 1'b1;
                  r_periodTicks <= '0;
                  r_highTicks   <= '0;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign period_ticks = r_periodTicks;
   assign high_ticks   = r_highTicks;
   assign valid        = r_valid;
   assign signal_lost  = r_signalLost;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed PWM waveforms checked every cycle against an edge-timestamp model.
// Honours PWM_CAPTURE_GLITCH_FILTER_EN so the same bench covers both builds.
module tb_pwm_capture;

   localparam int ClockFreq = 2000;
   localparam int MinFreq   = 10;
   localparam int Timeout   = ClockFreq / MinFreq;
   localparam int Cw        = $clog2(ClockFreq / MinFreq) + 1;
   localparam int FilterLen = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int Lat       = FilterLen + 2;
`else
   localparam int Lat       = 2;
`endif

   logic          pwmClk = 1'b0;
   logic          enable = 1'b0;
   logic          pwmIn  = 1'b0;
   logic [Cw-1:0] periodTicks;
   logic [Cw-1:0] highTicks;
   logic          valid;
   logic          signalLost;
   logic          level;

   int checks   = 0;
   int failures = 0;

   // Model state: timestamps (edge numbers) of the filtered input, plus the expected outputs.
   int   edgeN     = 0;
   int   lastRise  = -1;
   int   fallAt    = -1;
   logic fh [4]    = '{default: 1'b0};
   logic sHist [FilterLen] = '{default: 1'b0};
   logic sDel      = 1'b0;
   logic expValid  = 1'b0;
   logic expLost   = 1'b0;
   int   expPeriod = 0;
   int   expHigh   = 0;

   // Observations of the DUT used by the hand-computed literal checks.
   int   lastValidPeriod = -1;
   int   lastValidHigh   = -1;
   int   inRiseEdge      = 0;
   int   lostGap         = -1;
   logic sPrevRaw        = 1'b0;
   logic prevLost        = 1'b0;
   logic seenHigh2       = 1'b0;
   logic seenPeriod200   = 1'b0;
   logic lostSeen        = 1'b0;

   pwm_capture #(
      .clock_freq_hz  (ClockFreq),
      .min_pwm_freq_hz(MinFreq)
   ) dut (
      .pwm_clk     (pwmClk),
      .enable      (enable),
      .pwm_in      (pwmIn),
      .period_ticks(periodTicks),
      .high_ticks  (highTicks),
      .valid       (valid),
      .signal_lost (signalLost),
      .level       (level)
   );

   always #5 pwmClk = ~pwmClk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive reps periods of the given high time and period, changing the input on falling clock edges.
   task automatic applyStimulus(input int highCycles, input int periodCycles, input int reps);
      for (int r = 0; r < reps; r++) begin
         pwmIn = 1'b1;
         repeat (highCycles) @(negedge pwmClk);
         pwmIn = 1'b0;
         repeat (periodCycles - highCycles) @(negedge pwmClk);
      end
   endtask

   task automatic holdLevel(input logic v, input int cycles);
      pwmIn = v;
      repeat (cycles) @(negedge pwmClk);
   endtask

   // Per-edge model update followed by the cycle-by-cycle comparison against the DUT.
   always @(posedge pwmClk) begin
      logic sNow;
      logic enNow;
      logic fNew;
      logic rise;
      logic fall;
      logic allDiff;
      sNow  = pwmIn;
      enNow = enable;
      edgeN++;
      if (!enNow) begin
         for (int i = 0; i < 4; i++) fh[i] = 1'b0;
         for (int i = 0; i < FilterLen; i++) sHist[i] = 1'b0;
         sDel      = 1'b0;
         lastRise  = -1;
         fallAt    = -1;
         expValid  = 1'b0;
         expLost   = 1'b0;
         expPeriod = 0;
         expHigh   = 0;
      end else begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         for (int i = FilterLen - 1; i > 0; i--) sHist[i] = sHist[i-1];
         sHist[0] = sDel;
         sDel     = sNow;
         allDiff  = 1'b1;
         for (int i = 0; i < FilterLen; i++) if (sHist[i] == fh[0]) allDiff = 1'b0;
         fNew = allDiff ? sHist[0] : fh[0];
`else
         allDiff = 1'b0;
         fNew    = sNow;
`endif
         fh[3] = fh[2];
         fh[2] = fh[1];
         fh[1] = fh[0];
         fh[0] = fNew;
         rise = fh[2] & ~fh[3];
         fall = ~fh[2] & fh[3];
         expValid = 1'b0;
         if (rise) begin
            if (lastRise >= 0 && fallAt >= 0) begin
               expValid  = 1'b1;
               expPeriod = edgeN - lastRise;
               expHigh   = fallAt - lastRise;
               expLost   = 1'b0;
            end
            lastRise = edgeN;
            fallAt   = -1;
         end else if (fall && lastRise >= 0 && fallAt < 0) begin
            fallAt = edgeN;
         end
         if (!rise && lastRise >= 0 && edgeN - lastRise == Timeout) begin
            expLost   = 1'b1;
            expPeriod = 0;
            expHigh   = 0;
            lastRise  = -1;
            fallAt    = -1;
         end
      end
      if (sNow && !sPrevRaw) inRiseEdge = edgeN;
      sPrevRaw = sNow;

      #1;
      checkOutput("cycValid",  valid,       expValid);
      checkOutput("cycPeriod", periodTicks, expPeriod);
      checkOutput("cycHigh",   highTicks,   expHigh);
      checkOutput("cycLost",   signalLost,  expLost);
      checkOutput("cycLevel",  level,       enNow ? fh[1] : 1'b0);

      if (valid) begin
         lastValidPeriod = periodTicks;
         lastValidHigh   = highTicks;
         if (highTicks == 2) seenHigh2 = 1'b1;
         if (periodTicks == Cw'(Timeout)) seenPeriod200 = 1'b1;
      end
      if (signalLost && !prevLost) lostGap = edgeN - inRiseEdge;
      if (signalLost) lostSeen = 1'b1;
      prevLost = signalLost;
   end

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: simulation ran past its time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      $display("[TB] pwm_capture bench, timeout_ticks=%0d", Timeout);
      enable = 1'b0;
      pwmIn  = 1'b0;
      repeat (3) @(negedge pwmClk);
      checkOutput("rstPeriod", periodTicks, 0);
      checkOutput("rstHigh",   highTicks,   0);
      checkOutput("rstValid",  valid,       0);
      checkOutput("rstLost",   signalLost,  0);
      checkOutput("rstLevel",  level,       0);
      enable = 1'b1;

      // Lock onto a 20-tick period with 5 ticks high, then change duty to 12.
      applyStimulus(5, 20, 6);
      checkOutput("lockPeriod", lastValidPeriod, 20);
      checkOutput("lockHigh",   lastValidHigh,   5);
      applyStimulus(12, 20, 5);
      checkOutput("dutyPeriod", lastValidPeriod, 20);
      checkOutput("dutyHigh",   lastValidHigh,   12);

      // Input stuck low: loss reported Timeout cycles after the last detected rise.
      holdLevel(1'b0, Timeout + 50);
      checkOutput("lowLost",   signalLost,  1);
      checkOutput("lowPeriod", periodTicks, 0);
      checkOutput("lowHigh",   highTicks,   0);
      checkOutput("lowLevel",  level,       0);
      checkOutput("lowGap",    lostGap,     Timeout + Lat);
      applyStimulus(5, 20, 3);
      checkOutput("relockLost",   signalLost,      0);
      checkOutput("relockPeriod", lastValidPeriod, 20);

      // Input stuck high.
      holdLevel(1'b1, Timeout + 50);
      checkOutput("highLost",   signalLost,  1);
      checkOutput("highPeriod", periodTicks, 0);
      checkOutput("highLevel",  level,       1);
      checkOutput("highGap",    lostGap,     Timeout + Lat);
      holdLevel(1'b0, 15);
      applyStimulus(5, 20, 3);
      checkOutput("relock2Lost", signalLost, 0);
      checkOutput("relock2High", lastValidHigh, 5);

      // Reset pulse in the middle of a high phase.
      pwmIn = 1'b1;
      repeat (4) @(negedge pwmClk);
      enable = 1'b0;
      #1;
      checkOutput("midRstValid",  valid,       0);
      checkOutput("midRstPeriod", periodTicks, 0);
      checkOutput("midRstHigh",   highTicks,   0);
      checkOutput("midRstLost",   signalLost,  0);
      checkOutput("midRstLevel",  level,       0);
      @(negedge pwmClk);
      enable = 1'b1;
      @(negedge pwmClk);
      holdLevel(1'b0, 15);
      applyStimulus(5, 20, 3);
      checkOutput("postRstPeriod", lastValidPeriod, 20);

      // Two-cycle glitch inside a low phase.
      seenHigh2 = 1'b0;
      holdLevel(1'b1, 5);
      holdLevel(1'b0, 6);
      holdLevel(1'b1, 2);
      holdLevel(1'b0, 7);
      applyStimulus(5, 20, 3);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      checkOutput("glitchIgnored", seenHigh2, 0);
`else
      checkOutput("glitchSeen", seenHigh2, 1);
`endif

      // Period of exactly timeout_ticks: the rise wins over the timeout.
      lostSeen      = 1'b0;
      seenPeriod200 = 1'b0;
      applyStimulus(5, Timeout, 1);
      applyStimulus(5, 20, 2);
      checkOutput("edgeTimeoutPeriod", seenPeriod200, 1);
      checkOutput("edgeTimeoutLost",   lostSeen,      0);

      repeat (5) @(negedge pwmClk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
